// File: rtl/rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : rom_stream_reader
// Purpose  : Walks consecutive addresses of a 1-cycle-latency ROM and delivers
//            the words as a valid/ready stream with backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module rom_stream_reader #(
    parameter int ROMDEPTH = 16,
    parameter int WORDSIZE = 16,
    localparam int AW = $clog2(ROMDEPTH)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                start,
    input  logic [AW-1:0]       base_addr,
    input  logic [AW:0]         count,
    output logic                busy,
    output logic                done,
    output logic [AW-1:0]       rom_addr,
    input  logic [WORDSIZE-1:0] rom_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORDSIZE-1:0] out_data,
    output logic                out_last
);

    localparam logic [1:0]    c_ST_IDLE = 2'd0;
    localparam logic [1:0]    c_ST_RUN  = 2'd1;
    localparam logic [1:0]    c_ST_FIN  = 2'd2;
    localparam logic [AW-1:0] c_PTR_MAX = AW'(ROMDEPTH - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [AW:0]         r_count;
    logic [AW-1:0]       r_ptr;
    logic [AW:0]         r_issued;
    logic                r_inflight;
    logic                r_inflight_last;
    logic [1:0]          r_fifo_cnt;
    logic [WORDSIZE-1:0] r_head_data;
    logic                r_head_last;
    logic [WORDSIZE-1:0] r_tail_data;
    logic                r_tail_last;

    logic                w_accept;
    logic                w_push;
    logic                w_pop;
    logic                w_issue;
    logic [2:0]          w_occ_next;

    assign w_accept  = (r_state == c_ST_IDLE) && start;
    assign out_valid = (r_fifo_cnt != 2'd0);
    assign w_pop     = out_valid && out_ready;
    assign w_push    = r_inflight;

    // Occupancy after this edge, counting a same-cycle pop; one slot must
    // remain for the word a new issue would bring back, keeping 1 word/cycle.
    assign w_occ_next = {1'b0, r_fifo_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_issue    = (r_state == c_ST_RUN) && (r_issued < r_count) && (w_occ_next <= 3'd1);

    assign rom_addr = r_ptr;
    assign out_data = r_head_data;
    assign out_last = r_head_last;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_next = (count != '0) ? c_ST_RUN : c_ST_FIN;
                end
            end
            c_ST_RUN: begin
                if (w_pop && r_head_last) begin
                    w_state_next = c_ST_FIN;
                end
            end
            c_ST_FIN: w_state_next = c_ST_IDLE;
            default:  w_state_next = c_ST_IDLE;
        endcase
    end

    always_comb begin
        busy = (r_state == c_ST_RUN) || (r_state == c_ST_FIN);
        done = (r_state == c_ST_FIN);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_count         <= '0;
            r_ptr           <= '0;
            r_issued        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            if (w_accept) begin
                r_count  <= count;
                r_ptr    <= base_addr;
                r_issued <= '0;
            end else if (w_issue) begin
                r_ptr    <= (r_ptr == c_PTR_MAX) ? '0 : r_ptr + 1'b1;
                r_issued <= r_issued + 1'b1;
            end
            r_inflight <= w_issue;
            if (w_issue) begin
                r_inflight_last <= (r_issued == r_count - (AW+1)'(1));
            end
        end
    end

    // Two-entry FIFO held as explicit head/tail registers; head drives the stream.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fifo_cnt  <= 2'd0;
            r_head_data <= '0;
            r_head_last <= 1'b0;
            r_tail_data <= '0;
            r_tail_last <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_fifo_cnt == 2'd0) begin
                        r_head_data <= rom_data;
                        r_head_last <= r_inflight_last;
                    end else begin
                        r_tail_data <= rom_data;
                        r_tail_last <= r_inflight_last;
                    end
                    r_fifo_cnt <= r_fifo_cnt + 2'd1;
                end
                2'b01: begin
                    r_head_data <= r_tail_data;
                    r_head_last <= r_tail_last;
                    r_fifo_cnt  <= r_fifo_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_fifo_cnt == 2'd1) begin
                        r_head_data <= rom_data;
                        r_head_last <= r_inflight_last;
                    end else begin
                        r_head_data <= r_tail_data;
                        r_head_last <= r_tail_last;
                        r_tail_data <= rom_data;
                        r_tail_last <= r_inflight_last;
                    end
                end
                default: ;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(w_push && !w_pop && (r_fifo_cnt == 2'd2)));
    a_occupancy: assert property (@(posedge CLK) disable iff (RST)
        (({1'b0, r_fifo_cnt} + {2'b00, r_inflight}) <= 3'd2));

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_rom_stream_reader
// Purpose  : Self-checking bench: per-transfer word queue model, literal
//            timing pins, random transfers and backpressure.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rom_stream_reader;

    localparam int ROMDEPTH = 16;
    localparam int WORDSIZE = 16;
    localparam int AW       = 4;

    logic                CLK = 1'b0;
    logic                RST = 1'b1;
    logic                start = 1'b0;
    logic [AW-1:0]       base_addr = '0;
    logic [AW:0]         count = '0;
    logic                busy;
    logic                done;
    logic [AW-1:0]       rom_addr;
    logic [WORDSIZE-1:0] rom_data;
    logic                out_valid;
    logic                out_ready = 1'b1;
    logic [WORDSIZE-1:0] out_data;
    logic                out_last;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;

    logic [16:0] q[$];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;

    rom_stream_reader #(.ROMDEPTH(ROMDEPTH), .WORDSIZE(WORDSIZE)) dut (
        .CLK(CLK), .RST(RST), .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .rom_addr(rom_addr), .rom_data(rom_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
    );

    always #5 CLK = ~CLK;

    // ROM contents: rom[i] = A000 + i, one-cycle registered read
    always @(posedge CLK) rom_data <= 16'hA000 + 16'(rom_addr);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: expected word queue per transfer, busy/done per cycle
    initial begin
        logic [16:0] front;
        bit nb, nd;
        forever begin
            @(negedge CLK);
            if (RST) begin
                q.delete();
                m_busy = 1'b0;
                m_done = 1'b0;
            end else begin
                chk("busy", busy, m_busy);
                chk("done", done, m_done);
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_valid", out_valid, 1'b0);
                    end else begin
                        chk("out_data", out_data, q[0][15:0]);
                        chk("out_last", out_last, q[0][16]);
                    end
                end
                if (m_done) chk("words_left_at_done", q.size(), 0);
                nb = m_busy;
                nd = 1'b0;
                if (m_done) begin
                    nb = 1'b0;
                end else if (!m_busy && start) begin
                    nb = 1'b1;
                    if (count == 0) nd = 1'b1;
                    for (int i = 0; i < int'(count); i++) begin
                        q.push_back({(i == int'(count) - 1),
                                     16'hA000 + 16'((int'(base_addr) + i) % ROMDEPTH)});
                    end
                end
                if (out_valid && out_ready && q.size() > 0) begin
                    front = q.pop_front();
                    if (front[16]) nd = 1'b1;
                end
                m_busy = nb;
                m_done = nd;
            end
        end
    end

    initial begin
        int ph = 0;
        forever begin
            @(posedge CLK);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((ph % 3) == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            ph++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1, "watchdog");
    end

    task automatic pulse_start(input int b, input int c);
        @(posedge CLK);
        #1;
        start = 1'b1;
        base_addr = AW'(b);
        count = (AW+1)'(c);
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int  n = 0;
        bit  seen = 1'b0;
        while (n < limit && !seen) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
            n++;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL wait_done: done=0 after %0d cycles, expected 1", limit);
        end
    endtask

    // 4-word transfer with ready=1: pins addresses C1..C4, data C3..C6, done C7
    task automatic lit4(input int b, input logic [3:0] ea[4], input logic [15:0] ed[4]);
        @(posedge CLK);
        #1;
        start = 1'b1; base_addr = AW'(b); count = 5'd4;
        @(negedge CLK);
        @(posedge CLK);
        #1;
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge CLK);
            chk("lit_rom_addr", rom_addr, ea[k]);
            if (k < 2) chk("lit_valid_early", out_valid, 1'b0);
            else       chk("lit_data_early", out_data, ed[k-2]);
        end
        for (int k = 2; k < 4; k++) begin
            @(negedge CLK);
            chk("lit_valid", out_valid, 1'b1);
            chk("lit_data", out_data, ed[k]);
            chk("lit_last", out_last, (k == 3));
        end
        @(negedge CLK);
        chk("lit_done", done, 1'b1);
    endtask

    initial begin
        logic [3:0]  ea[4];
        logic [15:0] ed[4];
        int beats;

        #1;
        chk("rst_busy", busy, 1'b0);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_addr", rom_addr, 4'd0);
        chk("rst_data", out_data, 16'h0);
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        // Case 1: base 2, count 4
        ea = '{4'd2, 4'd3, 4'd4, 4'd5};
        ed = '{16'hA002, 16'hA003, 16'hA004, 16'hA005};
        lit4(2, ea, ed);

        // Case 2: wrap at the top of the ROM
        ea = '{4'd14, 4'd15, 4'd0, 4'd1};
        ed = '{16'hA00E, 16'hA00F, 16'hA000, 16'hA001};
        lit4(14, ea, ed);

        // Case 3: full ROM under 1,0,0 backpressure
        ready_mode = 1;
        pulse_start(0, 16);
        wait_done(200);
        ready_mode = 0;

        // Case 4: zero-length transfer
        @(posedge CLK);
        #1;
        start = 1'b1; base_addr = 4'd3; count = 5'd0;
        @(posedge CLK);
        #1;
        start = 1'b0;
        @(negedge CLK);
        chk("zero_busy", busy, 1'b1);
        chk("zero_done", done, 1'b1);
        chk("zero_valid", out_valid, 1'b0);
        @(negedge CLK);
        chk("zero_busy_after", busy, 1'b0);
        chk("zero_done_after", done, 1'b0);

        // Case 5: start re-pulsed mid-transfer is ignored
        ready_mode = 2;
        pulse_start(3, 10);
        repeat (3) @(posedge CLK);
        pulse_start(9, 5);
        wait_done(200);
        ready_mode = 0;

        // Case 6: reset mid-stream after two beats
        pulse_start(7, 8);
        beats = 0;
        for (int n = 0; n < 50 && beats < 2; n++) begin
            @(negedge CLK);
            if (out_valid && out_ready) beats++;
        end
        chk("pre_reset_beats", beats, 2);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        #1;
        chk("async_busy", busy, 1'b0);
        chk("async_done", done, 1'b0);
        chk("async_valid", out_valid, 1'b0);
        chk("async_last", out_last, 1'b0);
        chk("async_addr", rom_addr, 4'd0);
        chk("async_data", out_data, 16'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        start = 1'b1; base_addr = 4'd5; count = 5'd2;
        @(posedge CLK);
        #1;
        start = 1'b0;
        beats = 0;
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge CLK);
            if (out_valid && out_ready) begin
                chk("post_reset_data", out_data, (beats == 0) ? 16'hA005 : 16'hA006);
                beats++;
            end
        end
        chk("post_reset_beats", beats, 2);

        // Random transfers with random backpressure
        ready_mode = 2;
        for (int t = 0; t < 25; t++) begin
            pulse_start(int'($urandom_range(0, 15)), int'($urandom_range(0, 16)));
            wait_done(300);
        end

        repeat (3) @(posedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
